// File: rtl/regfile_wport_arbiter_if.sv
// Write-port bundle between two writeback requesters, the arbiter and the register file.
// The master side is the requester/testbench view; the slave side is the arbiter.
interface regfile_wport_arbiter_if;
  logic        req0_val;
  logic        req0_rdy;
  logic [4:0]  req0_waddr;
  logic [31:0] req0_wdata;
  logic        req1_val;
  logic        req1_rdy;
  logic [4:0]  req1_waddr;
  logic [31:0] req1_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        init_done;

  modport master (
    output req0_val, req0_waddr, req0_wdata,
    output req1_val, req1_waddr, req1_wdata,
    input  req0_rdy, req1_rdy,
    input  rf_wen, rf_waddr, rf_wdata, init_done
  );

  modport slave (
    input  req0_val, req0_waddr, req0_wdata,
    input  req1_val, req1_waddr, req1_wdata,
    output req0_rdy, req1_rdy,
    output rf_wen, rf_waddr, rf_wdata, init_done
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a post-reset
// sweep that writes INIT_VALUE into registers 1..31 (the register file has no reset).
module regfile_wport_arbiter #(
  parameter bit          INIT_EN    = 1'b1,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_wport_arbiter_if.slave  wp
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Returns {grant_valid, grant_index}; on a tie the requester not granted last wins.
  function automatic logic [1:0] rr_pick(input logic val0, input logic val1, input logic last);
    logic [1:0] pick;
    case ({val1, val0})
      2'b01:   pick = {1'b1, 1'b0};
      2'b10:   pick = {1'b1, 1'b1};
      2'b11:   pick = {1'b1, ~last};
      default: pick = {1'b0, 1'b0};
    endcase
    return pick;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [4:0]  cnt_r;
  logic [4:0]  cnt_nxt_s;
  logic        last_r;
  logic        last_nxt_s;

  logic [1:0]  pick_s;
  logic        gnt_valid_s;
  logic        gnt_idx_s;

  logic        wen_s;
  logic [4:0]  waddr_s;
  logic [31:0] wdata_s;
  logic        rdy0_s;
  logic        rdy1_s;
  logic        done_s;

  // Arbitration decision from the current requests and the last winner.
  always_comb begin
    pick_s      = rr_pick(wp.req0_val, wp.req1_val, last_r);
    gnt_valid_s = pick_s[1];
    gnt_idx_s   = pick_s[0];
  end

  // State register: synchronous active-low reset restarts the whole sequence.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= INIT_EN ? ST_INIT : ST_RUN;
      cnt_r   <= 5'd1;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Next-state and unmasked output decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    last_nxt_s  = last_r;
    wen_s       = 1'b0;
    waddr_s     = 5'd0;
    wdata_s     = 32'h0000_0000;
    rdy0_s      = 1'b0;
    rdy1_s      = 1'b0;
    done_s      = 1'b0;

    case (state_r)
      ST_INIT: begin
        // Requests are ignored here; requesters hold val until the sweep finishes.
        wen_s     = 1'b1;
        waddr_s   = cnt_r;
        wdata_s   = INIT_VALUE;
        cnt_nxt_s = cnt_r + 5'd1;
        if (cnt_r == 5'd31) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        done_s = 1'b1;
        if (gnt_valid_s) begin
          wen_s      = 1'b1;
          rdy0_s     = ~gnt_idx_s;
          rdy1_s     = gnt_idx_s;
          last_nxt_s = gnt_idx_s;
          if (gnt_idx_s) begin
            waddr_s = wp.req1_waddr;
            wdata_s = wp.req1_wdata;
          end else begin
            waddr_s = wp.req0_waddr;
            wdata_s = wp.req0_wdata;
          end
        end else begin
          last_nxt_s = last_r;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
        cnt_nxt_s   = 5'd1;
        last_nxt_s  = 1'b1;
      end
    endcase
  end

  // Outputs pass through in the same cycle but are held at zero while reset is low.
  always_comb begin
    if (!reset) begin
      wp.rf_wen    = 1'b0;
      wp.rf_waddr  = 5'd0;
      wp.rf_wdata  = 32'h0000_0000;
      wp.req0_rdy  = 1'b0;
      wp.req1_rdy  = 1'b0;
      wp.init_done = 1'b0;
    end else begin
      wp.rf_wen    = wen_s;
      wp.rf_waddr  = waddr_s;
      wp.rf_wdata  = wdata_s;
      wp.req0_rdy  = rdy0_s;
      wp.req1_rdy  = rdy1_s;
      wp.init_done = done_s;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: three instances (INIT with zero, RUN-at-reset,
// INIT with a non-zero pattern) share one stimulus and are checked against a cycle model.
module tb_regfile_wport_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        r0v, r1v;
  logic [4:0]  r0a, r1a;
  logic [31:0] r0d, r1d;

  int checks   = 0;
  int failures = 0;

  regfile_wport_arbiter_if if_a ();
  regfile_wport_arbiter_if if_b ();
  regfile_wport_arbiter_if if_c ();

  assign if_a.req0_val = r0v;  assign if_a.req0_waddr = r0a;  assign if_a.req0_wdata = r0d;
  assign if_a.req1_val = r1v;  assign if_a.req1_waddr = r1a;  assign if_a.req1_wdata = r1d;
  assign if_b.req0_val = r0v;  assign if_b.req0_waddr = r0a;  assign if_b.req0_wdata = r0d;
  assign if_b.req1_val = r1v;  assign if_b.req1_waddr = r1a;  assign if_b.req1_wdata = r1d;
  assign if_c.req0_val = r0v;  assign if_c.req0_waddr = r0a;  assign if_c.req0_wdata = r0d;
  assign if_c.req1_val = r1v;  assign if_c.req1_waddr = r1a;  assign if_c.req1_wdata = r1d;

  regfile_wport_arbiter #(.INIT_EN(1'b1), .INIT_VALUE(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .wp(if_a.slave));
  regfile_wport_arbiter #(.INIT_EN(1'b0), .INIT_VALUE(32'hA5A5_5A5A)) dut_b (
    .clk(clk), .reset(reset), .wp(if_b.slave));
  regfile_wport_arbiter #(.INIT_EN(1'b1), .INIT_VALUE(32'hC3A5_0F1E)) dut_c (
    .clk(clk), .reset(reset), .wp(if_c.slave));

  // {wen, waddr[4:0], wdata[31:0], rdy0, rdy1, init_done}
  logic [40:0] act [3];
  assign act[0] = {if_a.rf_wen, if_a.rf_waddr, if_a.rf_wdata, if_a.req0_rdy, if_a.req1_rdy, if_a.init_done};
  assign act[1] = {if_b.rf_wen, if_b.rf_waddr, if_b.rf_wdata, if_b.req0_rdy, if_b.req1_rdy, if_b.init_done};
  assign act[2] = {if_c.rf_wen, if_c.rf_waddr, if_c.rf_wdata, if_c.req0_rdy, if_c.req1_rdy, if_c.init_done};

  // Model: cycles since reset release, last winner, and a register-file image for dut_a.
  int          init_len [3] = '{31, 0, 31};
  logic [31:0] init_val [3] = '{32'h0000_0000, 32'hA5A5_5A5A, 32'hC3A5_0F1E};
  int          since    [3];
  bit          m_last   [3];
  logic [31:0] mem      [32];

  function automatic int model_grant(int d);
    if (r0v && r1v) return m_last[d] ? 0 : 1;
    if (r0v)        return 0;
    if (r1v)        return 1;
    return -1;
  endfunction

  function automatic logic [40:0] expect_out(int d);
    int g;
    if (!reset) return 41'd0;
    if (since[d] < init_len[d])
      return {1'b1, 5'(since[d] + 1), init_val[d], 1'b0, 1'b0, 1'b0};
    g = model_grant(d);
    if (g < 0) return {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1};
    if (g == 1) return {1'b1, r1a, r1d, 1'b0, 1'b1, 1'b1};
    return {1'b1, r0a, r0d, 1'b1, 1'b0, 1'b1};
  endfunction

  task automatic update_model();
    for (int d = 0; d < 3; d++) begin
      logic [40:0] e;
      int g;
      e = expect_out(d);
      g = model_grant(d);
      if (!reset) begin
        since[d]  = 0;
        m_last[d] = 1'b1;
      end else begin
        if (since[d] >= init_len[d] && g >= 0) m_last[d] = (g == 1);
        if (d == 0 && e[40] && e[39:35] != 5'd0) mem[e[39:35]] = e[34:3];
        if (since[d] < 1000) since[d] = since[d] + 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 3; d++) begin
      logic [40:0] e;
      e = expect_out(d);
      checks++;
      if (act[d] !== e) begin
        failures++;
        $display("FAIL cycle_cmp dut%0d t=%0t actual=%h required=%h", d, $time, act[d], e);
      end
    end
  endtask

  task automatic lit(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, actual, required);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle();
    r0v = 1'b0; r1v = 1'b0;
    r0a = 5'd0; r1a = 5'd0;
    r0d = 32'd0; r1d = 32'd0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick(); tick();

    // Power-up sweep: 31 writes to 1..31 then RUN with no requests.
    reset = 1'b1;
    for (int i = 0; i < 31; i++) begin
      #1;
      lit("init_wen",   32'(if_a.rf_wen),    32'd1);
      lit("init_addr",  32'(if_a.rf_waddr),  32'(i + 1));
      lit("init_data",  if_a.rf_wdata,       32'h0000_0000);
      lit("init_rdy",   32'({if_a.req0_rdy, if_a.req1_rdy}), 32'd0);
      lit("init_done0", 32'(if_a.init_done), 32'd0);
      if (i == 4) lit("init_data_c", if_c.rf_wdata, 32'hC3A5_0F1E);
      tick();
    end
    #1;
    lit("run_done", 32'(if_a.init_done), 32'd1);
    lit("run_idle", 32'(if_a.rf_wen),    32'd0);
    tick();

    // Both requesters held: strict alternation starting with requester 0.
    r0v = 1'b1; r0a = 5'd3; r0d = 32'h1111_1111;
    r1v = 1'b1; r1a = 5'd4; r1d = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      lit("alt_rdy0", 32'(if_a.req0_rdy), (i % 2 == 0) ? 32'd1 : 32'd0);
      lit("alt_addr", 32'(if_a.rf_waddr), (i % 2 == 0) ? 32'd3 : 32'd4);
      tick();
    end
    idle();
    tick();
    lit("rf_read3", mem[3], 32'h1111_1111);
    lit("rf_read4", mem[4], 32'h2222_2222);

    // Single requester 0: zero-latency pass-through.
    r0v = 1'b1; r0a = 5'd5; r0d = 32'hDEAD_BEEF;
    #1;
    lit("solo_wen",  32'(if_a.rf_wen),   32'd1);
    lit("solo_addr", 32'(if_a.rf_waddr), 32'd5);
    lit("solo_data", if_a.rf_wdata,      32'hDEAD_BEEF);
    lit("solo_rdy",  32'({if_a.req0_rdy, if_a.req1_rdy}), 32'b10);
    tick();
    idle();

    // Requester 1 alone, tie goes to 0, idle keeps last, next tie goes to 1.
    r1v = 1'b1; r1a = 5'd7; r1d = 32'h7777_7777;
    #1; lit("r1_alone", 32'({if_a.req0_rdy, if_a.req1_rdy}), 32'b01);
    tick();
    r0v = 1'b1; r0a = 5'd8; r0d = 32'h8888_8888;
    #1; lit("tie_after1", 32'({if_a.req0_rdy, if_a.req1_rdy}), 32'b10);
    lit("tie_after1_addr", 32'(if_a.rf_waddr), 32'd8);
    tick();
    idle();
    #1; lit("idle_wen", 32'(if_a.rf_wen), 32'd0);
    tick();
    r0v = 1'b1; r0a = 5'd8; r0d = 32'h8888_8888;
    r1v = 1'b1; r1a = 5'd7; r1d = 32'h7777_7777;
    #1; lit("tie_after_idle", 32'({if_a.req0_rdy, if_a.req1_rdy}), 32'b01);
    lit("tie_after_idle_addr", 32'(if_a.rf_waddr), 32'd7);
    tick();
    idle();
    tick();

    // Reset during the sweep at address 10 restarts it from address 1.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    #1; lit("mid_addr10", 32'(if_a.rf_waddr), 32'd10);
    reset = 1'b0;
    #1; lit("rst_outputs", 32'({if_a.rf_wen, if_a.rf_waddr, if_a.init_done, if_b.init_done}), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 31; i++) begin
      #1;
      lit("restart_addr", 32'(if_a.rf_waddr),  32'(i + 1));
      lit("restart_done", 32'(if_a.init_done), 32'd0);
      tick();
    end
    #1; lit("restart_fin", 32'(if_a.init_done), 32'd1);
    tick();

    // Without the sweep, a request on the first cycle after reset is served at once.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    r0v = 1'b1; r0a = 5'd9; r0d = 32'h1234_5678;
    #1;
    lit("noinit_done", 32'(if_b.init_done), 32'd1);
    lit("noinit_rdy0", 32'(if_b.req0_rdy),  32'd1);
    lit("noinit_wen",  32'(if_b.rf_wen),    32'd1);
    lit("noinit_addr", 32'(if_b.rf_waddr),  32'd9);
    lit("noinit_a_in_init", 32'(if_a.req0_rdy), 32'd0);
    tick();
    idle();
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
Shares the single write port of the 32x32b two-read/one-write register file (register 0 hardwired to zero) between two writeback requesters, using val/rdy handshakes and round-robin arbitration. After reset it runs an initialization sequence that writes a known value into registers 1..31, because the register file itself has no reset. It sits between the processor writeback sources (for example ALU and memory) and the register file write port (wen/waddr/wdata).

Parameters:
INIT_EN, 1, 1 = run the clear sequence after reset; 0 = enter RUN directly.
INIT_VALUE, 32'h0, data written to registers 1..31 during INIT.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset (low = reset asserted).
req0_val  input  1  requester 0 has a write pending.
req0_rdy  output  1  requester 0 write accepted this cycle.
req0_waddr  input  5  requester 0 destination register.
req0_wdata  input  32  requester 0 write data.
req1_val  input  1  requester 1 has a write pending.
req1_rdy  output  1  requester 1 write accepted this cycle.
req1_waddr  input  5  requester 1 destination register.
req1_wdata  input  32  requester 1 write data.
rf_wen  output  1  register file write enable.
rf_waddr  output  5  register file write address.
rf_wdata  output  32  register file write data.
init_done  output  1  high once INIT has completed (RUN state).

Behaviour:
- State: state {INIT, RUN}, cnt[4:0], last[0:0] (the most recently granted requester).
- Reset (reset==0 at a rising edge):
  - state <= INIT if INIT_EN, else RUN.
  - cnt <= 1.
  - last <= 1, so requester 0 wins the first tie.
- While reset is low, all outputs are forced to 0: rf_wen, rf_waddr, rf_wdata, both rdy, and init_done.
- A reset asserted mid-INIT or mid-RUN restarts from the reset state. No partial state survives.
- INIT:
  - Outputs: rf_wen=1, rf_waddr=cnt, rf_wdata=INIT_VALUE, req0_rdy=req1_rdy=0, init_done=0.
  - Each edge: cnt <= cnt+1.
  - When cnt==31 at an edge, state <= RUN.
  - INIT lasts exactly 31 cycles (addresses 1..31 in order). Register 0 is never written.
  - Incoming val signals are ignored and must be held by the requesters.
- RUN:
  - init_done=1. The state is absorbing until the next reset.
  - Grant is combinational from val and last:
    - only req0_val high: grant 0.
    - only req1_val high: grant 1.
    - both high: grant the requester != last.
    - neither high: no grant.
  - reqN_rdy=1 only for the granted requester. rdy may depend combinationally on val.
  - With a grant: rf_wen=1, and rf_waddr/rf_wdata are the granted requester's waddr/wdata, passed through in the same cycle (zero latency). The register file commits the write at the next rising edge.
  - With no grant: rf_wen=0, rf_waddr=0, rf_wdata=0.
  - last <= granted index on every transfer (val&&rdy); last is unchanged on idle cycles.
  - A write to waddr 0 is arbitrated and forwarded normally (rf_wen=1). The register file discards it.
- Requester rule: once val is high, val, waddr and wdata stay stable until rdy. The arbiter does not latch request data.
- Throughput: at most one write per cycle. With both requesters continuously valid, grants strictly alternate. Neither requester waits more than 1 cycle while the other is also valid.

Test Plan:
1. reset low 2 cycles, then high, INIT_EN=1, INIT_VALUE=0 -> cycles 1..31: rf_wen=1, rf_waddr=1..31, rf_wdata=0, both rdy=0, init_done=0; cycle 32: init_done=1, rf_wen=0 with no val.
2. RUN, req0_val=1, waddr=5, wdata=DEADBEEF, req1_val=0 -> same cycle: rf_wen=1, rf_waddr=5, rf_wdata=DEADBEEF, req0_rdy=1, req1_rdy=0.
3. RUN, both val held 4 cycles (req0: addr 3, data 11111111; req1: addr 4, data 22222222) -> grants 0,1,0,1; rf_waddr 3,4,3,4; a following regfile read of 3/4 returns 11111111/22222222.
4. RUN, req1 alone granted once (addr 7), then both valid -> req0 granted; then an idle cycle with rf_wen=0 and last unchanged; then both valid -> req1 granted.
5. reset low during INIT when cnt=10, then released -> INIT restarts at address 1 and lasts a full 31 cycles; init_done stays 0 throughout.
6. INIT_EN=0, req0_val=1 on the first cycle after reset release -> init_done=1, req0_rdy=1, rf_wen=1 in that same cycle.
